// File: rtl/ppu_load_scheduler.sv
// Frame-timing sequencer: dot/row counters, color and sprite load sequencing,
// VRAM read arbitration. Define PPU_SCHED_STATS_EN for the statistics counters.
module ppu_load_scheduler #(
  parameter int unsigned ROWS_VISIBLE     = 240,
  parameter int unsigned ROWS_TOTAL       = 262,
  parameter int unsigned COLS_TOTAL       = 341,
  parameter int unsigned SPRITE_START_COL = 257
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [8:0]  curr_row,
  output logic [8:0]  curr_col,
  output logic [8:0]  sprite_row,
  output logic        vblank,
  output logic        frame_start,
  output logic        color_start,
  input  logic        color_busy,
  output logic        sprite_start,
  input  logic        sprite_busy,
  input  logic        sprite_overflow,
  input  logic [15:0] color_vram_addr,
  input  logic [15:0] bg_vram_addr,
  output logic [15:0] vram_read_addr,
  output logic        color_grant,
  output logic        color_late,
  output logic        sprite_late,
  input  logic        err_clr,
  output logic [15:0] frame_count,
  output logic [7:0]  overflow_lines
);

  localparam logic [8:0] RV      = 9'(ROWS_VISIBLE);
  localparam logic [8:0] RV_M2   = 9'(ROWS_VISIBLE - 2);
  localparam logic [8:0] RT_LAST = 9'(ROWS_TOTAL - 1);
  localparam logic [8:0] CT_LAST = 9'(COLS_TOTAL - 1);
  localparam logic [8:0] SSC     = 9'(SPRITE_START_COL);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_HOLD  = 2'd2;
  localparam logic [1:0] C_WAIT  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_PEND  = 3'd4;

  logic [8:0] row_q, row_d;
  logic [8:0] col_q, col_d;
  logic [8:0] srow_q, srow_d;
  logic [8:0] prow_q, prow_d;
  logic [8:0] next_row;
  logic [1:0] c_q, c_d;
  logic [2:0] s_q, s_d;
  logic       pv_q, pv_d;
  logic       fs_q, fs_d;
  logic       cl_q, cl_d;
  logic       sl_q, sl_d;
  logic       trig_c, trig_s;
  logic       c_idle, s_exit;

  assign next_row = (row_q == RT_LAST) ? '0 : row_q + 9'd1;
  assign c_idle   = (c_q == C_IDLE);
  assign trig_c   = enable && (row_q == RV) && (col_q == '0);
  assign trig_s   = enable && (col_q == SSC) &&
                    ((row_q == RT_LAST) || (row_q <= RV_M2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    fs_d  = enable && (row_q == RT_LAST) && (col_q == CT_LAST);
    if (enable) begin
      if (col_q == CT_LAST) begin
        col_d = '0;
        row_d = next_row;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  always_comb begin
    c_d = c_q;
    unique case (c_q)
      C_IDLE:  if (trig_c) c_d = C_START;
      C_START: c_d = C_HOLD;
      C_HOLD:  c_d = C_WAIT;
      C_WAIT:  if (!color_busy) c_d = C_IDLE;
      default: c_d = C_IDLE;
    endcase
  end

  always_comb begin
    s_d    = s_q;
    srow_d = srow_q;
    prow_d = prow_q;
    pv_d   = pv_q;
    s_exit = 1'b0;
    unique case (s_q)
      S_IDLE: begin
        if (trig_s) begin
          if (c_idle) begin
            s_d    = S_START;
            srow_d = next_row;
          end else begin
            s_d = S_PEND;
          end
        end
      end
      S_START: s_d = S_HOLD;
      S_HOLD:  s_d = S_WAIT;
      S_WAIT: begin
        if (!sprite_busy) begin
          s_exit = 1'b1;
          s_d    = (pv_q || trig_s) ? S_PEND : S_IDLE;
        end
      end
      S_PEND: begin
        if (c_idle) begin
          s_d    = S_START;
          srow_d = prow_q;
          pv_d   = 1'b0;
        end
      end
      default: s_d = S_IDLE;
    endcase
    // a trigger that cannot issue now becomes the single held request
    if (trig_s && !((s_q == S_IDLE) && c_idle)) begin
      pv_d   = 1'b1;
      prow_d = next_row;
    end
  end

  always_comb begin
    cl_d = cl_q;
    sl_d = sl_q;
    if (err_clr) begin
      cl_d = 1'b0;
      sl_d = 1'b0;
    end
    if ((row_q == RT_LAST) && (col_q == '0) && !c_idle) cl_d = 1'b1;
    if ((col_q == '0) && (row_q == srow_q) && (s_q != S_IDLE)) sl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      srow_q <= '0;
      prow_q <= '0;
      c_q    <= C_IDLE;
      s_q    <= S_IDLE;
      pv_q   <= 1'b0;
      fs_q   <= 1'b0;
      cl_q   <= 1'b0;
      sl_q   <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      srow_q <= srow_d;
      prow_q <= prow_d;
      c_q    <= c_d;
      s_q    <= s_d;
      pv_q   <= pv_d;
      fs_q   <= fs_d;
      cl_q   <= cl_d;
      sl_q   <= sl_d;
    end
  end

  assign curr_row       = row_q;
  assign curr_col       = col_q;
  assign sprite_row     = srow_q;
  assign vblank         = (row_q >= RV) && (row_q < RT_LAST);
  assign frame_start    = fs_q;
  assign color_start    = !rst && (c_q == C_START);
  assign sprite_start   = !rst && (s_q == S_START);
  assign color_grant    = !rst && !c_idle;
  assign vram_read_addr = color_grant ? color_vram_addr : bg_vram_addr;
  assign color_late     = cl_q;
  assign sprite_late    = sl_q;

`ifdef PPU_SCHED_STATS_EN
  logic [15:0] fc_q, fc_d;
  logic [7:0]  ol_q, ol_d;

  always_comb begin
    fc_d = fs_q ? fc_q + 16'd1 : fc_q;
    ol_d = ol_q;
    if (s_exit && sprite_overflow && (ol_q != 8'hff)) ol_d = ol_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q <= '0;
      ol_q <= '0;
    end else begin
      fc_q <= fc_d;
      ol_q <= ol_d;
    end
  end

  assign frame_count    = fc_q;
  assign overflow_lines = ol_q;
`else
  logic unused_stats;
  assign unused_stats   = sprite_overflow ^ s_exit;
  assign frame_count    = '0;
  assign overflow_lines = '0;
`endif

endmodule

// File: tb/tb_ppu_load_scheduler.sv
// Bench for ppu_load_scheduler: directed frame scenarios plus random stimulus
// against a load-age reference model, on a 6x16 frame.
module tb_ppu_load_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        color_busy = 1'b0;
  logic        sprite_busy = 1'b0;
  logic        sprite_overflow = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] color_vram_addr = '0;
  logic [15:0] bg_vram_addr = '0;
  logic [8:0]  curr_row, curr_col, sprite_row;
  logic        vblank, frame_start, color_start, sprite_start;
  logic [15:0] vram_read_addr;
  logic        color_grant, color_late, sprite_late;
  logic [15:0] frame_count;
  logic [7:0]  overflow_lines;

  always #5 clk = ~clk;

  ppu_load_scheduler #(
    .ROWS_VISIBLE(4), .ROWS_TOTAL(6), .COLS_TOTAL(16), .SPRITE_START_COL(10)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .curr_row(curr_row), .curr_col(curr_col), .sprite_row(sprite_row),
    .vblank(vblank), .frame_start(frame_start),
    .color_start(color_start), .color_busy(color_busy),
    .sprite_start(sprite_start), .sprite_busy(sprite_busy),
    .sprite_overflow(sprite_overflow),
    .color_vram_addr(color_vram_addr), .bg_vram_addr(bg_vram_addr),
    .vram_read_addr(vram_read_addr), .color_grant(color_grant),
    .color_late(color_late), .sprite_late(sprite_late), .err_clr(err_clr),
    .frame_count(frame_count), .overflow_lines(overflow_lines)
  );

  int n_vec = 0;
  int n_err = 0;

  bit rst_v = 1, en_v = 0, clr_v = 0, ovf_v = 0;
  int cb_n = 5, sb_n = 3;

  int m_row, m_col, m_srow, m_prow;
  int m_c_age, m_c_n, m_s_age, m_s_n;
  bit m_pend, m_fs, m_cl, m_sl;
  int m_fc, m_ol;

  int gr_cnt, cs_cnt, ss_cnt, ss_row, ss_col;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_row = 0; m_col = 0; m_srow = 0; m_prow = 0;
    m_c_age = -1; m_c_n = 0; m_s_age = -1; m_s_n = 0;
    m_pend = 0; m_fs = 0; m_cl = 0; m_sl = 0;
    m_fc = 0; m_ol = 0;
  endtask

  task automatic m_step();
    bit tc, ts, c_idle, s_idle, c_exit, s_exit;
    int nrow;
    if (rst) begin
      m_reset();
      return;
    end
    tc = enable && m_row == 4 && m_col == 0;
    ts = enable && m_col == 10 && (m_row == 5 || m_row <= 2);
    nrow = (m_row + 1) % 6;
    c_idle = m_c_age < 0;
    s_idle = m_s_age < 0 && !m_pend;
    c_exit = m_c_age >= 2 && !color_busy;
    s_exit = m_s_age >= 2 && !sprite_busy;
    if (m_row == 5 && m_col == 0 && !c_idle) m_cl = 1;
    else if (err_clr) m_cl = 0;
    if (m_col == 0 && m_row == m_srow && !s_idle) m_sl = 1;
    else if (err_clr) m_sl = 0;
    if (m_fs) m_fc = (m_fc + 1) % 65536;
    if (s_exit && sprite_overflow && m_ol < 255) m_ol++;
    m_fs = enable && m_row == 5 && m_col == 15;
    if (!c_idle) m_c_age = c_exit ? -1 : m_c_age + 1;
    else if (tc) begin m_c_age = 0; m_c_n = cb_n; end
    if (m_s_age >= 0) m_s_age = s_exit ? -1 : m_s_age + 1;
    else if (m_pend && c_idle) begin
      m_s_age = 0; m_srow = m_prow; m_pend = 0; m_s_n = sb_n;
    end else if (ts && c_idle) begin
      m_s_age = 0; m_srow = nrow; m_s_n = sb_n;
    end
    if (ts && !(s_idle && c_idle)) begin m_pend = 1; m_prow = nrow; end
    if (enable) begin
      if (m_col == 15) begin m_col = 0; m_row = nrow; end
      else m_col++;
    end
  endtask

  task automatic check_outputs();
    bit g;
    g = !rst && m_c_age >= 0;
    chk("curr_row", curr_row, m_row);
    chk("curr_col", curr_col, m_col);
    chk("sprite_row", sprite_row, m_srow);
    chk("vblank", vblank, (m_row >= 4 && m_row < 5));
    chk("frame_start", frame_start, m_fs);
    chk("color_start", color_start, (!rst && m_c_age == 0));
    chk("sprite_start", sprite_start, (!rst && m_s_age == 0));
    chk("color_grant", color_grant, g);
    chk("vram_addr", vram_read_addr, g ? color_vram_addr : bg_vram_addr);
    chk("color_late", color_late, m_cl);
    chk("sprite_late", sprite_late, m_sl);
`ifdef PPU_SCHED_STATS_EN
    chk("frame_count", frame_count, m_fc);
    chk("overflow_lines", overflow_lines, m_ol);
`else
    chk("frame_count", frame_count, 0);
    chk("overflow_lines", overflow_lines, 0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst = rst_v;
    enable = en_v;
    err_clr = clr_v;
    sprite_overflow = ovf_v;
    color_busy = m_c_age >= 1 && m_c_age <= m_c_n;
    sprite_busy = m_s_age >= 1 && m_s_age <= m_s_n;
    color_vram_addr = 16'($urandom);
    bg_vram_addr = 16'($urandom);
    #4;
    check_outputs();
    if (color_grant) gr_cnt++;
    if (color_start) cs_cnt++;
    if (sprite_start) begin
      ss_cnt++;
      ss_row = int'(curr_row);
      ss_col = int'(curr_col);
    end
    m_step();
  endtask

  task automatic run_to(input int r, input int c);
    int n = 0;
    while (!(m_row == r && m_col == c) && n < 500) begin
      cycle();
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_err++;
      $error("FAIL run_to obs=%0d,%0d exp=%0d,%0d", m_row, m_col, r, c);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    cycle();
    cycle();
    rst_v = 0;
    en_v = 1;
    ovf_v = 1;

    gr_cnt = 0; ss_cnt = 0;
    cycle();
    run_to(0, 0);
    chk("grant_window", gr_cnt, 7);
    chk("sprite_loads", ss_cnt, 4);

    cb_n = 25;
    cycle();
    run_to(0, 0);
    cb_n = 5;
    chk("color_overrun", color_late, 1);
    chk("pend_row", ss_row, 5);
    chk("pend_col", ss_col, 13);

    run_to(0, 4);
    clr_v = 1;
    cycle();
    clr_v = 0;
    cycle();
    chk("clr_color", color_late, 0);
    chk("clr_sprite", sprite_late, 0);
    sb_n = 10;
    run_to(0, 12);
    sb_n = 3;
    run_to(1, 2);
    chk("sprite_overrun", sprite_late, 1);
    clr_v = 1;
    cycle();
    clr_v = 0;
    cycle();
    chk("sprite_clr", sprite_late, 0);
    run_to(0, 0);

    run_to(2, 5);
    en_v = 0;
    cs_cnt = 0; ss_cnt = 0;
    repeat (10) cycle();
    chk("hold_row", curr_row, 2);
    chk("hold_col", curr_col, 5);
    chk("hold_starts", cs_cnt + ss_cnt, 0);
    en_v = 1;
    run_to(0, 0);

    run_to(4, 4);
    rst_v = 1;
    cycle();
    rst_v = 0;
    cycle();
    chk("rst_row", curr_row, 0);
    chk("rst_col", curr_col, 0);
    chk("rst_grant", color_grant, 0);
    chk("rst_vram", vram_read_addr, bg_vram_addr);

    repeat (400) begin
      en_v  = $urandom_range(0, 9) != 0;
      clr_v = $urandom_range(0, 19) == 0;
      ovf_v = $urandom_range(0, 1) == 1;
      cb_n  = $urandom_range(0, 40);
      sb_n  = $urandom_range(0, 20);
      cycle();
    end

    en_v = 1; clr_v = 0; ovf_v = 1; cb_n = 5; sb_n = 3;
    rst_v = 1;
    cycle();
    rst_v = 0;
    repeat (290) cycle();
`ifdef PPU_SCHED_STATS_EN
    chk("stats_frames", frame_count, 3);
    chk("stats_ovf", overflow_lines, 12);
`else
    chk("stats_frames", frame_count, 0);
    chk("stats_ovf", overflow_lines, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
